// File: rtl/mdu_seq.sv
`timescale 1ns/1ps
// mdu_seq: multi-cycle multiply/divide unit with HI/LO result registers (MIPS style).
// Define MDU_SIGNED_EN for two's-complement MULT/DIV; otherwise they alias MULTU/DIVU.
module mdu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N-1:0]   opr;
  logic           is_div;
  logic           accept, move;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     add_sum, shifted;
  logic [N-1:0]   trial;
  logic           fits;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;
  logic [N-1:0]   res_hi, res_lo;

  assign accept = start && !op[2] && (state == IDLE);
  assign move   = start && op[2] && !op[1] && (state == IDLE);
  assign busy   = (state != IDLE);

  // acc is {accumulator high half, multiplier} for mult and {remainder, quotient} for div
  assign add_sum = {1'b0, acc[2*N-1:N]} + {1'b0, opr};
  assign shifted = {acc[2*N-1:N], acc[N-1]};
  assign trial   = shifted[N-1:0] - opr;
  assign fits    = (shifted >= {1'b0, opr});

`ifdef MDU_SIGNED_EN
  localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE2 = {{(2*N-1){1'b0}}, 1'b1};

  logic a_neg, b_neg, a_neg_q, b_neg_q;

  assign a_neg = op[0] && a[N-1];
  assign b_neg = op[0] && b[N-1];
  assign a_mag = a_neg ? (~a + ONE) : a;
  assign b_mag = b_neg ? (~b + ONE) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else if (accept) begin
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
    end
  end

  // After a divide by zero the remainder holds |a|, so the dividend-sign fix restores a as presented
  always_comb begin
    prod = acc;
    quo  = acc[N-1:0];
    rem  = acc[2*N-1:N];
    if (a_neg_q ^ b_neg_q) begin
      prod = ~acc + ONE2;
      quo  = ~acc[N-1:0] + ONE;
    end
    if (a_neg_q) begin
      rem = ~acc[2*N-1:N] + ONE;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = acc;
  assign quo   = acc[N-1:0];
  assign rem   = acc[2*N-1:N];
`endif

  always_comb begin
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
    if (is_div) begin
      res_hi = rem;
      res_lo = (opr == '0) ? '1 : quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (cnt == '0) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opr    <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= op[1];
            cnt    <= CW'(N-1);
            opr    <= op[1] ? b_mag : a_mag;
            acc    <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
          end else if (move) begin
            if (op[0]) lo <= a;
            else       hi <= a;
            done <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            if (fits) acc <= {trial, acc[N-2:0], 1'b1};
            else      acc <= {shifted[N-1:0], acc[N-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {add_sum, acc[N-1:1]};
            else        acc <= {1'b0, acc[2*N-1:1]};
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
